regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001: Parameter XLEN, default 32, data width in bits (32 or 64).
- REQ-002: Parameter NREG, default 32, number of architectural registers (power of two, 8..64); AW = clog2(NREG).
- REQ-003: Clocking and reset are fixed: reset reset, synchronous, active-high; clock clk.
- REQ-004: clk  in  1  rising-edge clock.
- REQ-005: reset  in  1  synchronous active-high reset.
- REQ-006: rs_a, rs_b  in  AW each  read-port register indices.
- REQ-007: rdata_a, rdata_b  out  XLEN each  read-port data.
- REQ-008: busy_a, busy_b  out  1 each  source register has an outstanding write.
- REQ-009: iss_valid  in  1  marks iss_rd pending; iss_rd  in  AW  destination being issued.
- REQ-010: wb_valid  in  1  write-back strobe; wb_rd  in  AW  destination; wb_data  in  XLEN  raw write-back word.
- REQ-011: wb_op  in  3  extension mode: W=0, B=1, BU=2, H=3, HU=4; 5..7 reserved.
- REQ-012: wb_addr_lo  in  2  low byte-address bits of the load.
- REQ-013: pend_cnt  out  AW+1  number of busy registers.
- REQ-014: err_misalign  out  1  sticky misaligned/illegal write-back flag.

Function
- REQ-015: Reads are combinational; index 0 always returns 0.
- REQ-016: Extension: B/BU select byte wb_addr_lo of wb_data, sign/zero-extended to XLEN; H/HU select halfword wb_addr_lo[1], sign/zero-extended; W passes wb_data unchanged.
- REQ-017: Write-back with wb_valid=1, wb_rd!=0 and a legal op writes the extended value at the next rising edge.
- REQ-018: Illegal write-back (H/HU with wb_addr_lo[0]=1, or wb_op 5..7): register unchanged, err_misalign set at next edge, busy[wb_rd] still cleared.
- REQ-019: Bypass: if wb_valid=1, legal, wb_rd==rs_x and rs_x!=0, rdata_x returns the extended write-back value in the same cycle.
- REQ-020: Scoreboard: iss_valid=1 with iss_rd!=0 sets busy[iss_rd] at next edge; wb_valid=1 clears busy[wb_rd] at next edge.
- REQ-021: Simultaneous issue and write-back to the same register: busy stays/becomes 1 (issue wins); data is still written.
- REQ-022: busy_x = busy[rs_x] AND NOT (wb_valid AND wb_rd==rs_x); busy_x=0 when rs_x=0.
- REQ-023: Register 0 is never written and never busy.
- REQ-024: pend_cnt is a registered counter equal to the popcount of busy bits after each edge: +1 on set of a clear bit, -1 on clear of a set bit, unchanged when both or neither occur; never exceeds NREG-1.
- REQ-025: Write-back to a non-busy register is legal; it writes data and leaves pend_cnt unchanged.
- REQ-026: err_misalign stays 1 until reset.

Reset
- REQ-027: reset=1 at a rising edge clears all registers, busy bits, pend_cnt and err_misalign; reset overrides simultaneous iss_valid and wb_valid.
- REQ-028: Reset reached mid-operation discards all outstanding busy state; pending write-backs arriving later are treated as REQ-025.

Structure
- REQ-029: Package regfile_pkg holds the wb_op encodings and default XLEN/NREG constants.
- REQ-030: Extension logic is one combinational sub-module load_ext (inputs wb_data, wb_op, wb_addr_lo; outputs ext_data, illegal), shared by write and bypass paths.

Verification
- REQ-031: wb B, addr_lo=2, wb_data=0x0080_FF00, rd=5 -> r5=0xFFFF_FF80; same with BU -> 0x0000_0080.
- REQ-032: wb H, addr_lo=3, rd=6 -> r6 unchanged, err_misalign=1 next cycle and held.
- REQ-033: iss rd=7, next cycle rs_a=7 -> busy_a=1, pend_cnt=1; wb W rd=7 data=0x1234 with rs_a=7 -> same-cycle rdata_a=0x1234, busy_a=0; next cycle pend_cnt=0.
- REQ-034: Same-cycle iss rd=9 and wb rd=9 (r9 busy) -> r9 written, busy[9]=1, pend_cnt unchanged.
- REQ-035: iss/wb to rd=0 -> rdata=0, busy=0, pend_cnt=0.
- REQ-036: Issue 3 registers, assert reset with wb_valid=1 -> all regs 0, pend_cnt=0, err_misalign=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared write-back extension encodings and default register-file sizing
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_B  = 3'd1;
  localparam logic [2:0] OP_BU = 3'd2;
  localparam logic [2:0] OP_H  = 3'd3;
  localparam logic [2:0] OP_HU = 3'd4;
endpackage

// File: rtl/load_ext.sv
// load_ext: extracts and sign/zero-extends a write-back word; flags misaligned halfwords and reserved ops
// Ports: wb_data/wb_op/wb_addr_lo in, ext_data out (XLEN), illegal out
module load_ext
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] wb_data,
  input  logic [2:0]      wb_op,
  input  logic [1:0]      wb_addr_lo,
  output logic [XLEN-1:0] ext_data,
  output logic            illegal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = wb_data[{wb_addr_lo, 3'b000} +: 8];
  assign w_half = wb_data[{wb_addr_lo[1], 4'b0000} +: 16];
  assign illegal = (wb_op > OP_HU) || (((wb_op == OP_H) || (wb_op == OP_HU)) && wb_addr_lo[0]);
  always_comb begin
    ext_data = wb_data;
    ext_data = (wb_op == OP_B)  ? {{(XLEN-8){w_byte[7]}}, w_byte}   :
               (wb_op == OP_BU) ? {{(XLEN-8){1'b0}}, w_byte}        :
               (wb_op == OP_H)  ? {{(XLEN-16){w_half[15]}}, w_half} :
               (wb_op == OP_HU) ? {{(XLEN-16){1'b0}}, w_half}       : wb_data;
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read register file with write-back extension, same-cycle bypass and busy scoreboard
// Ports: clk/reset; rs_a/rs_b -> rdata_a/b, busy_a/b; iss_valid/iss_rd; wb_valid/wb_rd/wb_data/wb_op/wb_addr_lo;
//        pend_cnt (busy popcount), err_misalign (sticky illegal write-back)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs_a,
  input  logic [AW-1:0]   rs_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [2:0]      wb_op,
  input  logic [1:0]      wb_addr_lo,
  output logic [AW:0]     pend_cnt,
  output logic            err_misalign
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_pend;
  logic            r_err;
  logic [XLEN-1:0] w_ext;
  logic            w_illegal;
  logic            w_we;
  logic            w_iss;
  logic            w_set;
  logic            w_clr;
  logic [NREG-1:0] w_busy_nxt;

  load_ext #(.XLEN(XLEN)) u_ext (
    .wb_data    (wb_data),
    .wb_op      (wb_op),
    .wb_addr_lo (wb_addr_lo),
    .ext_data   (w_ext),
    .illegal    (w_illegal)
  );

  assign w_we  = wb_valid && (wb_rd != '0) && !w_illegal;
  assign w_iss = iss_valid && (iss_rd != '0);
  // issue beats write-back on the same register, so a clear only counts when no re-issue lands on it
  assign w_set = w_iss && !r_busy[iss_rd];
  assign w_clr = wb_valid && r_busy[wb_rd] && !(w_iss && (iss_rd == wb_rd));

  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_rd] = 1'b0;
    if (w_iss) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_we) r_regs[wb_rd] <= w_ext;
      r_busy <= w_busy_nxt;
      r_pend <= r_pend + {{AW{1'b0}}, w_set} - {{AW{1'b0}}, w_clr};
      r_err  <= r_err | (wb_valid & w_illegal);
    end
  end

  always_comb begin
    rdata_a = (rs_a == '0) ? '0 : (w_we && (wb_rd == rs_a)) ? w_ext : r_regs[rs_a];
    rdata_b = (rs_b == '0) ? '0 : (w_we && (wb_rd == rs_b)) ? w_ext : r_regs[rs_b];
    busy_a  = (rs_a != '0) && r_busy[rs_a] && !(wb_valid && (wb_rd == rs_a));
    busy_b  = (rs_b != '0) && r_busy[rs_b] && !(wb_valid && (wb_rd == rs_b));
  end

  assign pend_cnt     = r_pend;
  assign err_misalign = r_err;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector self-checking bench for regfile_sb
module tb_regfile_sb;
  import regfile_pkg::*;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   rs_a, rs_b, iss_rd, wb_rd;
  logic [XLEN-1:0] rdata_a, rdata_b, wb_data;
  logic            busy_a, busy_b, iss_valid, wb_valid, err_misalign;
  logic [2:0]      wb_op;
  logic [1:0]      wb_addr_lo;
  logic [AW:0]     pend_cnt;
  int n_tests = 0;
  int n_fail = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .rs_a(rs_a), .rs_b(rs_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_op(wb_op),
    .wb_addr_lo(wb_addr_lo), .pend_cnt(pend_cnt), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; wb_op = OP_W; wb_addr_lo = 0;
  endtask

  task automatic wb(input logic [AW-1:0] rd, input logic [2:0] op, input logic [1:0] lo, input logic [31:0] d);
    wb_valid = 1; wb_rd = rd; wb_op = op; wb_addr_lo = lo; wb_data = d;
  endtask

  initial begin
    idle();
    rs_a = 0; rs_b = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    rs_a = 5;
    #1;
    check("rst_pend", pend_cnt, 0);
    check("rst_err", err_misalign, 0);
    check("rst_r5", rdata_a, 0);
    check("rst_busy", busy_a, 0);
    // signed byte from lane 2, with same-cycle bypass
    wb(5, OP_B, 2, 32'h0080_FF00);
    #1;
    check("byp_b", rdata_a, 32'hFFFF_FF80);
    tick();
    idle();
    #1;
    check("wr_b", rdata_a, 32'hFFFF_FF80);
    check("wr_b_pend", pend_cnt, 0);
    wb(5, OP_BU, 2, 32'h0080_FF00);
    tick();
    idle();
    #1;
    check("wr_bu", rdata_a, 32'h0000_0080);
    wb(8, OP_H, 0, 32'h0080_FF00);
    tick();
    wb(4, OP_HU, 2, 32'h8765_4321);
    tick();
    wb(3, OP_B, 1, 32'h1234_7F00);
    tick();
    idle();
    rs_a = 8; rs_b = 4;
    #1;
    check("wr_h", rdata_a, 32'hFFFF_FF00);
    check("wr_hu", rdata_b, 32'h0000_8765);
    rs_a = 3;
    #1;
    check("wr_b_pos", rdata_a, 32'h0000_007F);
    // misaligned halfword: no write, no bypass, sticky error
    wb(6, OP_W, 0, 32'h11);
    tick();
    wb(6, OP_H, 3, 32'hDEAD_BEEF);
    rs_a = 6;
    #1;
    check("mis_nobyp", rdata_a, 32'h11);
    check("mis_err_pre", err_misalign, 0);
    tick();
    idle();
    #1;
    check("mis_r6", rdata_a, 32'h11);
    check("mis_err", err_misalign, 1);
    wb(6, 3'd5, 0, 32'h99);
    tick();
    idle();
    tick();
    #1;
    check("rsv_r6", rdata_a, 32'h11);
    check("mis_hold", err_misalign, 1);
    // scoreboard set/clear with bypass
    iss_valid = 1; iss_rd = 7;
    tick();
    idle();
    rs_a = 7;
    #1;
    check("iss_busy", busy_a, 1);
    check("iss_pend", pend_cnt, 1);
    wb(7, OP_W, 0, 32'h1234);
    #1;
    check("wb_byp", rdata_a, 32'h1234);
    check("wb_busy", busy_a, 0);
    tick();
    idle();
    #1;
    check("wb_pend", pend_cnt, 0);
    // issue and write-back to same busy register
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 1; iss_rd = 9;
    wb(9, OP_W, 0, 32'hABCD);
    tick();
    idle();
    rs_b = 9;
    #1;
    check("same_data", rdata_b, 32'hABCD);
    check("same_busy", busy_b, 1);
    check("same_pend", pend_cnt, 1);
    wb(9, OP_W, 0, 32'hABCD);
    tick();
    idle();
    #1;
    check("clr9_pend", pend_cnt, 0);
    // register 0 is never written nor busy
    iss_valid = 1; iss_rd = 0;
    wb(0, OP_W, 0, 32'h55);
    rs_a = 0;
    #1;
    check("r0_byp", rdata_a, 0);
    tick();
    idle();
    #1;
    check("r0_rd", rdata_a, 0);
    check("r0_busy", busy_a, 0);
    check("r0_pend", pend_cnt, 0);
    // issue one while retiring another
    iss_valid = 1; iss_rd = 10;
    tick();
    iss_valid = 1; iss_rd = 11;
    wb(10, OP_W, 0, 32'h1);
    tick();
    idle();
    rs_a = 11; rs_b = 10;
    #1;
    check("swap_pend", pend_cnt, 1);
    check("swap_b11", busy_a, 1);
    check("swap_b10", busy_b, 0);
    // reset with outstanding issues and a write-back in flight
    iss_valid = 1; iss_rd = 1;
    tick();
    iss_rd = 2;
    tick();
    iss_rd = 3;
    tick();
    idle();
    #1;
    check("pre_rst_pend", pend_cnt, 4);
    reset = 1;
    iss_valid = 1; iss_rd = 12;
    wb(1, OP_W, 0, 32'hCAFE);
    tick();
    reset = 0;
    idle();
    rs_a = 1; rs_b = 5;
    #1;
    check("rst2_pend", pend_cnt, 0);
    check("rst2_err", err_misalign, 0);
    check("rst2_r1", rdata_a, 0);
    check("rst2_r5", rdata_b, 0);
    wb(2, OP_W, 0, 32'h77);
    tick();
    idle();
    rs_a = 2;
    #1;
    check("late_wb", rdata_a, 32'h77);
    check("late_pend", pend_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
